// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller/datapath signal bundle for the multicycle MIPS core
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done, illegal_op, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM sequencing the shared multicycle MIPS datapath
module mips_multicycle_ctrl (
    input  logic                    clk,
    input  logic                    reset,
    mips_multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BEQ    = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] { ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2 } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t  cur;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  if (bus.mem_ready) cur <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BEQ;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= (bus.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (bus.mem_ready) cur <= MEMWB;
                MEMWR:  if (bus.mem_ready) cur <= FETCH;
                EXEC:   cur <= ALUWB;
                ADDIEX: cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        alu_op         = ALU_ADD;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (cur)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                pc_write    = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: bus.illegal_op = 1'b0;
                    default:                                       bus.illegal_op = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.MemtoReg   = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.IorD       = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                alu_op      = ALU_FUNCT;
            end
            ALUWB: begin
                bus.RegDst     = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA    = 1'b1;
                bus.PCSrc      = 2'b01;
                alu_op         = ALU_SUB;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            ADDIWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.PCSrc      = 2'b10;
                pc_write       = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase

        bus.PCEn = pc_write | (branch & bus.zero);

        case (alu_op)
            ALU_SUB:   bus.ALUControl = 3'b110;
            ALU_FUNCT: begin
                case (bus.funct)
                    6'b100010: bus.ALUControl = 3'b110;
                    6'b100100: bus.ALUControl = 3'b000;
                    6'b100101: bus.ALUControl = 3'b001;
                    6'b101010: bus.ALUControl = 3'b111;
                    default:   bus.ALUControl = 3'b010;
                endcase
            end
            default:   bus.ALUControl = 3'b010;
        endcase

        // Reset is asynchronous, so the strobes must be gated here rather than relying on the state register alone.
        if (reset) begin
            bus.mem_req    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.PCEn       = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

    assign bus.state = cur;
endmodule
